// File: rtl/branch_resolve_ctrl.sv
// Misprediction recovery sequencer: detect -> one-cycle flush/checkpoint restore -> held frontend redirect.
// Optional counters are enabled with `define BRANCH_RESOLVE_STATS_EN.
module branch_resolve_ctrl #(
    parameter int CHKP_W = 2,
    parameter int GL_W   = 6,
    parameter int XLEN   = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              br_valid_i,
    input  logic [XLEN-1:0]   br_pc_i,
    input  logic              br_taken_i,
    input  logic [XLEN-1:0]   br_target_i,
    input  logic              br_ex_valid_i,
    input  logic              pred_taken_i,
    input  logic [XLEN-1:0]   pred_target_i,
    input  logic [CHKP_W-1:0] br_chkp_i,
    input  logic [GL_W-1:0]   br_gl_index_i,
    input  logic              kill_i,
    input  logic              fe_ready_i,
    output logic              busy_o,
    output logic              flush_o,
    output logic              recover_valid_o,
    output logic [CHKP_W-1:0] recover_chkp_o,
    output logic [GL_W-1:0]   recover_gl_index_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]       stat_branches_o,
    output logic [31:0]       stat_mispredicts_o
`endif
);

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    state_t            state;
    logic [XLEN-1:0]   pc_q;
    logic [CHKP_W-1:0] chkp_q;
    logic [GL_W-1:0]   gl_q;

    logic              mispredict;
    logic              detect;
    logic [XLEN-1:0]   correct_pc;

    assign mispredict = (br_taken_i != pred_taken_i) ||
                        (br_taken_i && (br_target_i != pred_target_i));
    assign correct_pc = br_taken_i ? br_target_i : br_pc_i + XLEN'(4);
    // Excepting branches are left for commit to handle; kill pre-empts everything.
    assign detect     = (state == IDLE) && br_valid_i && mispredict &&
                        !br_ex_valid_i && !kill_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            pc_q   <= '0;
            chkp_q <= '0;
            gl_q   <= '0;
        end else if (kill_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (detect) begin
                        state  <= FLUSH;
                        pc_q   <= correct_pc;
                        chkp_q <= br_chkp_i;
                        gl_q   <= br_gl_index_i;
                    end
                end
                FLUSH:    state <= REDIRECT;
                REDIRECT: if (fe_ready_i) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Recovery outputs are gated by kill in the same cycle so commit always wins.
    assign flush_o            = (state == FLUSH) && !kill_i;
    assign recover_valid_o    = flush_o;
    assign recover_chkp_o     = recover_valid_o ? chkp_q : '0;
    assign recover_gl_index_o = recover_valid_o ? gl_q : '0;
    assign redirect_valid_o   = (state == REDIRECT) && !kill_i;
    assign redirect_pc_o      = redirect_valid_o ? pc_q : '0;
    assign busy_o             = (state != IDLE) || (detect && !rst_i);

`ifdef BRANCH_RESOLVE_STATS_EN
    logic br_accept;
    assign br_accept = (state == IDLE) && br_valid_i && !kill_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_branches_o    <= '0;
            stat_mispredicts_o <= '0;
        end else begin
            if (br_accept && (stat_branches_o != '1))
                stat_branches_o <= stat_branches_o + 32'd1;
            if (detect && (stat_mispredicts_o != '1))
                stat_mispredicts_o <= stat_mispredicts_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: transaction-timestamp reference model feeds a per-cycle
// expectation queue consumed by an independent monitor.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid_i = 1'b0;
    logic [63:0] br_pc_i = '0;
    logic        br_taken_i = 1'b0;
    logic [63:0] br_target_i = '0;
    logic        br_ex_valid_i = 1'b0;
    logic        pred_taken_i = 1'b0;
    logic [63:0] pred_target_i = '0;
    logic [1:0]  br_chkp_i = '0;
    logic [5:0]  br_gl_index_i = '0;
    logic        kill_i = 1'b0;
    logic        fe_ready_i = 1'b0;
    logic        busy_o, flush_o, recover_valid_o, redirect_valid_o;
    logic [1:0]  recover_chkp_o;
    logic [5:0]  recover_gl_index_o;
    logic [63:0] redirect_pc_o;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_branches_o, stat_mispredicts_o;
`endif

    branch_resolve_ctrl #(.CHKP_W(2), .GL_W(6), .XLEN(64)) dut (
        .clk_i(clk), .rst_i(rst),
        .br_valid_i(br_valid_i), .br_pc_i(br_pc_i), .br_taken_i(br_taken_i),
        .br_target_i(br_target_i), .br_ex_valid_i(br_ex_valid_i),
        .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
        .br_chkp_i(br_chkp_i), .br_gl_index_i(br_gl_index_i),
        .kill_i(kill_i), .fe_ready_i(fe_ready_i),
        .busy_o(busy_o), .flush_o(flush_o), .recover_valid_o(recover_valid_o),
        .recover_chkp_o(recover_chkp_o), .recover_gl_index_o(recover_gl_index_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
`ifdef BRANCH_RESOLVE_STATS_EN
        ,
        .stat_branches_o(stat_branches_o), .stat_mispredicts_o(stat_mispredicts_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy, flush, rv, dv;
        logic [1:0]  chkp;
        logic [5:0]  gl;
        logic [63:0] dpc;
        logic [31:0] sb, sm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: one outstanding recovery described by its detect cycle.
    int          cyc = 0;
    bit          m_active = 0;
    int          m_d = 0;
    logic [63:0] m_pc = '0;
    logic [1:0]  m_ck = '0;
    logic [5:0]  m_gl = '0;
    logic [31:0] m_sb = '0, m_sm = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy", 64'(busy_o), 64'(e.busy));
            chk("flush", 64'(flush_o), 64'(e.flush));
            chk("recover_valid", 64'(recover_valid_o), 64'(e.rv));
            chk("recover_chkp", 64'(recover_chkp_o), 64'(e.chkp));
            chk("recover_gl", 64'(recover_gl_index_o), 64'(e.gl));
            chk("redirect_valid", 64'(redirect_valid_o), 64'(e.dv));
            chk("redirect_pc", redirect_pc_o, e.dpc);
`ifdef BRANCH_RESOLVE_STATS_EN
            chk("stat_branches", 64'(stat_branches_o), 64'(e.sb));
            chk("stat_mispredicts", 64'(stat_mispredicts_o), 64'(e.sm));
`endif
        end
    end

    task automatic drive(input logic r, input logic bv, input logic [63:0] pc, input logic tk,
                         input logic [63:0] tg, input logic ex, input logic pt,
                         input logic [63:0] ptg, input logic [1:0] ck, input logic [5:0] gl,
                         input logic kl, input logic fr);
        exp_t e;
        bit   mis;
        @(posedge clk); #1;
        rst = r; br_valid_i = bv; br_pc_i = pc; br_taken_i = tk; br_target_i = tg;
        br_ex_valid_i = ex; pred_taken_i = pt; pred_target_i = ptg; br_chkp_i = ck;
        br_gl_index_i = gl; kill_i = kl; fe_ready_i = fr;
        e.busy = 0; e.flush = 0; e.rv = 0; e.dv = 0; e.chkp = '0; e.gl = '0; e.dpc = '0;
        if (r) begin
            m_active = 0; m_sb = 0; m_sm = 0;
        end
        e.sb = m_sb; e.sm = m_sm;
        if (!r && m_active) begin
            e.busy = 1;
            if (cyc == m_d + 1) begin
                if (kl) m_active = 0;
                else begin e.flush = 1; e.rv = 1; e.chkp = m_ck; e.gl = m_gl; end
            end else if (kl) begin
                m_active = 0;
            end else begin
                e.dv = 1; e.dpc = m_pc;
                if (fr) m_active = 0;
            end
        end else if (!r) begin
            mis = (tk != pt) || (tk && tg != ptg);
            if (bv && !kl) m_sb = m_sb + 1;
            if (bv && mis && !ex && !kl) begin
                e.busy = 1; m_active = 1; m_d = cyc;
                m_pc = tk ? tg : pc + 64'd4;
                m_ck = ck; m_gl = gl; m_sm = m_sm + 1;
            end
        end
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input logic kl, input logic fr);
        drive(0, 0, '0, 0, '0, 0, 0, '0, '0, '0, kl, fr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pc, tg, ptg;
        logic        tk, pt;
        repeat (3) drive(1, 0, '0, 0, '0, 0, 0, '0, '0, '0, 0, 0);
        idle(0, 1);
        // Correctly predicted taken branch: no recovery.
        drive(0, 1, 64'h8000_0000, 1, 64'h8000_0100, 0, 1, 64'h8000_0100, 2'd2, 6'd17, 0, 1);
        // Same branch predicted not-taken: minimum-latency recovery.
        drive(0, 1, 64'h8000_0000, 1, 64'h8000_0100, 0, 0, 64'h8000_0100, 2'd2, 6'd17, 0, 1);
        repeat (3) idle(0, 1);
        // Fall-through PC wrap, redirect held 5 cycles, plus an ignored younger mispredict.
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h1234, 0, 1, 64'h1234, 2'd1, 6'd5, 0, 0);
        idle(0, 0);
        idle(0, 0);
        drive(0, 1, 64'h4000, 1, 64'h5000, 0, 0, 64'h0, 2'd3, 6'd9, 0, 0);
        repeat (3) idle(0, 0);
        idle(0, 1);
        repeat (2) idle(0, 1);
        // Excepting mispredict: nothing issued.
        drive(0, 1, 64'h100, 1, 64'h202, 1, 0, 64'h0, 2'd1, 6'd3, 0, 1);
        repeat (2) idle(0, 1);
        // Kill during the flush cycle cancels the recovery.
        drive(0, 1, 64'h100, 1, 64'h200, 0, 0, 64'h0, 2'd3, 6'd40, 0, 1);
        idle(1, 1);
        repeat (3) idle(0, 1);
        // Async reset while a redirect is being held.
        drive(0, 1, 64'h300, 0, 64'h0, 0, 1, 64'h0, 2'd2, 6'd7, 0, 0);
        idle(0, 0);
        idle(0, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_flush", 64'(flush_o), 64'd0);
        chk("rst_recover_valid", 64'(recover_valid_o), 64'd0);
        chk("rst_recover_chkp", 64'(recover_chkp_o), 64'd0);
        chk("rst_recover_gl", 64'(recover_gl_index_o), 64'd0);
        chk("rst_redirect_valid", 64'(redirect_valid_o), 64'd0);
        chk("rst_redirect_pc", redirect_pc_o, 64'd0);
        repeat (2) drive(1, 0, '0, 0, '0, 0, 0, '0, '0, '0, 0, 1);
        repeat (2) idle(0, 1);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            pc = {$urandom, $urandom & 32'hFFFF_FFFC};
            if ($urandom_range(0, 15) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC;
            tg  = {$urandom, $urandom};
            tk  = 1'($urandom_range(0, 1));
            pt  = ($urandom_range(0, 3) == 0) ? ~tk : tk;
            ptg = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : tg;
            drive(0, 1'($urandom_range(0, 1)), pc, tk, tg, $urandom_range(0, 9) == 0, pt, ptg,
                  2'($urandom), 6'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6);
        end
        repeat (4) idle(0, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences misprediction recovery after the execute-stage branch unit resolves a branch. Compares the resolved outcome against the fetch-time prediction. On a mismatch it drives a one-cycle pipeline flush and checkpoint restore, then holds a redirect to the frontend until the frontend accepts it. Sits between the exe-stage branch unit output and the frontend/rename recovery interfaces.

Parameters:
CHKP_W, 2, checkpoint index width (4 checkpoints)
GL_W, 6, graduation-list index width
XLEN, 64, PC/target width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
br_valid_i  in  1  resolved branch present this cycle
br_pc_i  in  XLEN  branch PC
br_taken_i  in  1  resolved taken
br_target_i  in  XLEN  resolved target (result_pc)
br_ex_valid_i  in  1  branch raised misaligned-target exception
pred_taken_i  in  1  predicted taken
pred_target_i  in  XLEN  predicted target
br_chkp_i  in  CHKP_W  checkpoint of branch
br_gl_index_i  in  GL_W  graduation-list index of branch
kill_i  in  1  global flush from commit (exception/CSR)
fe_ready_i  in  1  frontend accepts redirect
busy_o  out  1  recovery in progress; upstream must hold branch issue
flush_o  out  1  kill younger in-flight instructions
recover_valid_o  out  1  restore rename checkpoint
recover_chkp_o  out  CHKP_W  checkpoint to restore
recover_gl_index_o  out  GL_W  GL index of mispredicted branch
redirect_valid_o  out  1  frontend redirect request
redirect_pc_o  out  XLEN  corrected fetch PC

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0, including latched PC/chkp/gl_index.
- Mispredict = br_taken_i != pred_taken_i, OR (br_taken_i AND br_target_i != pred_target_i). Target compare uses all XLEN bits.
- Correct PC = br_taken_i ? br_target_i : br_pc_i + 4. Sum truncated to XLEN, wraps modulo 2^XLEN.
- States: IDLE, FLUSH, REDIRECT.
- IDLE:
  - If br_valid_i, mispredict, !br_ex_valid_i and !kill_i: latch correct PC, br_chkp_i, br_gl_index_i; go to FLUSH next cycle.
  - Otherwise stay in IDLE.
  - Correctly predicted branches and excepting branches produce no outputs. Exceptions are left to commit.
- FLUSH (exactly 1 cycle):
  - flush_o=1, recover_valid_o=1, recover_chkp_o/recover_gl_index_o = latched values.
  - Next state is REDIRECT.
- REDIRECT:
  - redirect_valid_o=1, redirect_pc_o = latched PC, both held stable until fe_ready_i=1.
  - The handshake completes in the cycle where redirect_valid_o and fe_ready_i are both 1; go to IDLE next cycle.
  - fe_ready_i may already be high on entry, giving minimum latency: detect at cycle N, flush at N+1, redirect accepted at N+2, IDLE at N+3.
- busy_o=1 in FLUSH and REDIRECT. Combinationally 1 in IDLE in the cycle a mispredict is detected.
- br_valid_i while not in IDLE is ignored. Such branches are younger and are killed by the flush.
- kill_i has priority in every state: next state IDLE. No flush, recover or redirect is issued in any cycle kill_i=1 (outputs gated combinationally).
- redirect_pc_o, recover_chkp_o and recover_gl_index_o are 0 whenever their valid is 0.

Optional Feature:
Macro BRANCH_RESOLVE_STATS_EN.
- With it defined, two additional outputs exist, both counters reset to 0 by rst_i and saturating at all-ones:
  - stat_branches_o (32 bits): increments on every br_valid_i accepted in IDLE without kill_i.
  - stat_mispredicts_o (32 bits): increments on each IDLE→FLUSH transition.
- Without it, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset mid-REDIRECT (fe_ready_i=0, then rst_i=1 asynchronously) -> all outputs 0 immediately; IDLE after release.
- br_valid_i=1, pc=0x8000_0000, taken=1, target=0x8000_0100, pred_taken=1, pred_target=0x8000_0100 -> no flush/redirect, busy_o=0.
- Same branch with pred_taken=0, chkp=2, gl=17, fe_ready_i=1 -> flush_o and recover_valid_o at N+1 with chkp 2 and gl 17; redirect_pc_o=0x8000_0100 accepted at N+2; IDLE at N+3.
- pc=0xFFFF_FFFF_FFFF_FFFC, taken=0, pred_taken=1 -> redirect_pc_o=0x0 (wrap). Hold fe_ready_i=0 for 5 cycles -> redirect_valid_o and redirect_pc_o stable the whole time.
- Mispredict with br_ex_valid_i=1 -> no outputs. Separately, kill_i=1 during FLUSH -> flush_o=0 that cycle, IDLE next cycle, no redirect.
- Second br_valid_i mispredict during REDIRECT -> ignored; redirect_pc_o unchanged. With BRANCH_RESOLVE_STATS_EN, after all cases: stat_branches_o and stat_mispredicts_o match the accepted-branch and IDLE→FLUSH counts.
